// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer
//   Receives a 9-byte command frame from a UART (op byte, operand A LSB
//   first, operand B LSB first), launches one FPU operation, and returns the
//   32-bit result to the host as 4 bytes, MSB first.
//
// Ports
//   clk, reset      system clock; asynchronous active-low reset
//   rx_data/rx_valid    byte stream from the UART receiver
//   tx_data/tx_start    byte and one-cycle send strobe to the UART transmitter
//   tx_busy/tx_done     transmitter status / one-cycle byte-sent strobe
//   fpu_op/fpu_a/fpu_b  operation (00 add, 01 mul, 10 div, 11 sub) and operands
//   fpu_start           one-cycle launch strobe
//   fpu_done/fpu_result completion strobe and result from the FPU
//   busy                high whenever the sequencer is not idle
//   err_op/err_timeout/err_overrun  one-cycle error pulses
module fpu_cmd_sequencer #(
   parameter int unsigned BYTE_TIMEOUT = 1_000_000,
   parameter int unsigned FPU_TIMEOUT  = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic [1:0]  fpu_op,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic        fpu_start,
   input  logic        fpu_done,
   input  logic [31:0] fpu_result,
   output logic        busy,
   output logic        err_op,
   output logic        err_timeout,
   output logic        err_overrun
);

   typedef enum logic [2:0] {
      IDLE, RX_A, RX_B, EXEC, WAIT, TX_LOAD, TX_WAIT
   } state_t;

   localparam logic [31:0] BYTE_LAST = 32'(BYTE_TIMEOUT - 1);
   localparam logic [31:0] FPU_LAST  = 32'(FPU_TIMEOUT - 1);
   localparam logic [31:0] QNAN      = 32'h7FC0_0000;

   state_t      state;
   logic [1:0]  bcnt;
   logic [31:0] tcnt;
   logic [31:0] result;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bcnt        <= '0;
         tcnt        <= '0;
         result      <= '0;
         fpu_op      <= '0;
         fpu_a       <= '0;
         fpu_b       <= '0;
         tx_data     <= '0;
         fpu_start   <= 1'b0;
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         err_op      <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         fpu_start   <= 1'b0;
         tx_start    <= 1'b0;
         err_op      <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (rx_data[7:2] == '0) begin
                     fpu_op <= rx_data[1:0];
                     bcnt   <= '0;
                     tcnt   <= '0;
                     busy   <= 1'b1;
                     state  <= RX_A;
                  end else begin
                     err_op <= 1'b1;
                  end
               end
            end

            RX_A, RX_B: begin
               // A byte arriving on the threshold cycle wins over the timeout.
               if (rx_valid) begin
                  if (state == RX_A) fpu_a[{bcnt, 3'b000} +: 8] <= rx_data;
                  else               fpu_b[{bcnt, 3'b000} +: 8] <= rx_data;
                  bcnt <= bcnt + 2'd1;
                  tcnt <= '0;
                  if (bcnt == 2'd3) begin
                     if (state == RX_A) begin
                        state <= RX_B;
                     end else begin
                        // Raised on entry so the strobe is visible during EXEC.
                        fpu_start <= 1'b1;
                        state     <= EXEC;
                     end
                  end
               end else if (tcnt == BYTE_LAST) begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  bcnt        <= '0;
                  tcnt        <= '0;
                  state       <= IDLE;
               end else begin
                  tcnt <= tcnt + 32'd1;
               end
            end

            EXEC: begin
               tcnt  <= '0;
               state <= WAIT;
            end

            WAIT: begin
               if (fpu_done) begin
                  result <= fpu_result;
                  // Launch byte 0 straight from fpu_result when the transmitter
                  // is free, skipping TX_LOAD to keep one-cycle result latency.
                  if (!tx_busy) begin
                     tx_data  <= fpu_result[31:24];
                     tx_start <= 1'b1;
                     state    <= TX_WAIT;
                  end else begin
                     state <= TX_LOAD;
                  end
               end else if (tcnt == FPU_LAST) begin
                  result      <= QNAN;
                  err_timeout <= 1'b1;
                  state       <= TX_LOAD;
               end else begin
                  tcnt <= tcnt + 32'd1;
               end
            end

            TX_LOAD: begin
               if (!tx_busy) begin
                  tx_data  <= result[{~bcnt, 3'b000} +: 8];
                  tx_start <= 1'b1;
                  state    <= TX_WAIT;
               end
            end

            TX_WAIT: begin
               if (tx_done) begin
                  if (bcnt == 2'd3) begin
                     bcnt  <= '0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     bcnt  <= bcnt + 2'd1;
                     state <= TX_LOAD;
                  end
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

         if (rx_valid && (state inside {EXEC, WAIT, TX_LOAD, TX_WAIT}))
            err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb_fpu_cmd_sequencer
//   Directed frames against fpu_cmd_sequencer with behavioural FPU and UART
//   transmitter models. Expected commands, transmitted bytes and error pulses
//   are queued by the stimulus and consumed by independent monitors.
module tb_fpu_cmd_sequencer;

   localparam int unsigned BT = 40;
   localparam int unsigned FT = 30;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        tx_done;
   logic [1:0]  fpu_op;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic        fpu_start;
   logic        fpu_done;
   logic [31:0] fpu_result;
   logic        busy;
   logic        err_op;
   logic        err_timeout;
   logic        err_overrun;

   logic tx_busy_model;
   logic tx_busy_force;
   assign tx_busy = tx_busy_model | tx_busy_force;

   fpu_cmd_sequencer #(.BYTE_TIMEOUT(BT), .FPU_TIMEOUT(FT)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
      .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_start(fpu_start),
      .fpu_done(fpu_done), .fpu_result(fpu_result),
      .busy(busy), .err_op(err_op), .err_timeout(err_timeout), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } cmd_t;

   cmd_t       exp_cmd[$];
   logic [7:0] exp_tx[$];
   int         exp_err[$];   // 1 = op, 2 = timeout, 3 = overrun

   int n_cmp  = 0;
   int n_fail = 0;
   int n_tx_start = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- FPU model ----------------
   bit          fpu_resp_en = 1'b1;
   int          fpu_delay   = 3;
   int          fpu_cnt     = 0;

   always @(negedge clk) begin
      if (!reset) begin
         fpu_done = 1'b0;
         fpu_cnt  = 0;
      end else begin
         fpu_done = 1'b0;
         if (fpu_cnt > 0) begin
            fpu_cnt--;
            if (fpu_cnt == 0) fpu_done = 1'b1;
         end
         if (fpu_start && fpu_resp_en) fpu_cnt = fpu_delay;
      end
   end

   // ---------------- UART transmitter model ----------------
   int         tx_cnt = 0;
   logic [7:0] tx_hold;

   always @(negedge clk) begin
      if (!reset) begin
         tx_done       = 1'b0;
         tx_busy_model = 1'b0;
         tx_cnt        = 0;
      end else begin
         tx_done = 1'b0;
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
               check("tx_data_stable", {24'h0, tx_data}, {24'h0, tx_hold});
               tx_done       = 1'b1;
               tx_busy_model = 1'b0;
            end
         end
         if (tx_start) begin
            tx_hold       = tx_data;
            tx_busy_model = 1'b1;
            tx_cnt        = 4;
         end
      end
   end

   // ---------------- Monitors ----------------
   always @(negedge clk) begin : mon_cmd
      cmd_t c;
      if (fpu_start) begin
         if (exp_cmd.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL fpu_start: got unexpected strobe op=%h a=%h b=%h, expected none",
                     fpu_op, fpu_a, fpu_b);
         end else begin
            c = exp_cmd.pop_front();
            check("fpu_op", {30'h0, fpu_op}, {30'h0, c.op});
            check("fpu_a", fpu_a, c.a);
            check("fpu_b", fpu_b, c.b);
         end
      end
   end

   always @(negedge clk) begin : mon_tx
      logic [7:0] e;
      if (tx_start) begin
         n_tx_start++;
         if (exp_tx.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL tx_start: got unexpected byte %h, expected none", tx_data);
         end else begin
            e = exp_tx.pop_front();
            check("tx_byte", {24'h0, tx_data}, {24'h0, e});
         end
      end
   end

   task automatic pop_err(input int code);
      if (exp_err.size() == 0) begin
         n_cmp++; n_fail++;
         $display("FAIL err_pulse: got unexpected error code %0d, expected none", code);
      end else begin
         check("err_kind", 32'(code), 32'(exp_err.pop_front()));
      end
   endtask

   always @(negedge clk) begin : mon_err
      if (err_op)      pop_err(1);
      if (err_timeout) pop_err(2);
      if (err_overrun) pop_err(3);
   end

   // ---------------- Stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      send_byte({6'h0, op});
      for (int unsigned i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      for (int unsigned i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      cmd_t c;
      c.op = op; c.a = a; c.b = b;
      exp_cmd.push_back(c);
   endtask

   task automatic push_tx(input logic [31:0] r);
      exp_tx.push_back(r[31:24]);
      exp_tx.push_back(r[23:16]);
      exp_tx.push_back(r[15:8]);
      exp_tx.push_back(r[7:0]);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((busy || exp_tx.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         n_cmp++; n_fail++;
         $display("FAIL %s: got still busy after %0d cycles, expected return to idle", name, n);
      end else begin
         repeat (2) @(negedge clk);
         check(name, {31'h0, busy}, 32'h0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},      {31'h0, busy},        32'h0);
      check({tag, "_strobes"},   {30'h0, fpu_start, tx_start}, 32'h0);
      check({tag, "_errs"},      {29'h0, err_op, err_timeout, err_overrun}, 32'h0);
      check({tag, "_fpu_op"},    {30'h0, fpu_op},      32'h0);
      check({tag, "_fpu_a"},     fpu_a,                32'h0);
      check({tag, "_fpu_b"},     fpu_b,                32'h0);
      check({tag, "_tx_data"},   {24'h0, tx_data},     32'h0);
   endtask

   // ---------------- Main sequence ----------------
   initial begin
      int n;
      int s;
      reset         = 1'b0;
      rx_valid      = 1'b0;
      rx_data       = '0;
      fpu_result    = '0;
      tx_busy_force = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // ADD: 3.5 + 2.0 = 5.5
      push_cmd(2'b00, 32'h4060_0000, 32'h4000_0000);
      fpu_result = 32'h40B0_0000;
      push_tx(32'h40B0_0000);
      send_frame(2'b00, 32'h4060_0000, 32'h4000_0000);
      wait_idle(200, "add_idle");

      // Invalid op byte leaves fpu_op alone, then SUB: 5.5 - 2.0 = 3.5
      exp_err.push_back(1);
      send_byte(8'h07);
      repeat (3) @(negedge clk);
      check("badop_fpu_op", {30'h0, fpu_op}, 32'h0);
      check("badop_busy", {31'h0, busy}, 32'h0);
      push_cmd(2'b11, 32'h40B0_0000, 32'h4000_0000);
      fpu_result = 32'h4060_0000;
      push_tx(32'h4060_0000);
      send_frame(2'b11, 32'h40B0_0000, 32'h4000_0000);
      wait_idle(200, "sub_idle");
      check("sub_fpu_op", {30'h0, fpu_op}, 32'h3);

      // Inter-byte stall: DIV op plus two A bytes, then silence
      exp_err.push_back(2);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      n = 0;
      while (busy && n < 2 * int'(BT)) begin
         @(negedge clk);
         n++;
      end
      check("stall_cycles", 32'(n), 32'(BT));
      repeat (5) @(negedge clk);
      check("stall_idle", {31'h0, busy}, 32'h0);

      // FPU hang: DIV 1.0 / 0.0, no fpu_done -> quiet NaN returned
      fpu_resp_en = 1'b0;
      push_cmd(2'b10, 32'h3F80_0000, 32'h0000_0000);
      exp_err.push_back(2);
      push_tx(32'h7FC0_0000);
      send_frame(2'b10, 32'h3F80_0000, 32'h0000_0000);
      wait_idle(300, "hang_idle");
      fpu_resp_en = 1'b1;

      // Overrun during WAIT, transmitter held busy for 50 cycles
      fpu_delay     = 10;
      tx_busy_force = 1'b1;
      push_cmd(2'b00, 32'h3F80_0000, 32'h3F80_0000);
      fpu_result = 32'h4000_0000;
      push_tx(32'h4000_0000);
      send_frame(2'b00, 32'h3F80_0000, 32'h3F80_0000);
      repeat (2) @(negedge clk);
      exp_err.push_back(3);
      send_byte(8'h55);
      n = 0;
      while (!fpu_done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("overrun_fpu_done_seen", {31'h0, fpu_done}, 32'h1);
      s = n_tx_start;
      repeat (50) @(negedge clk);
      check("txbusy_no_start", 32'(n_tx_start - s), 32'h0);
      tx_busy_force = 1'b0;
      wait_idle(200, "overrun_idle");
      fpu_delay = 3;

      // Reset in TX_WAIT after two bytes have gone out
      push_cmd(2'b00, 32'h4060_0000, 32'h4000_0000);
      fpu_result = 32'h40B0_0000;
      exp_tx.push_back(8'h40);
      exp_tx.push_back(8'hB0);
      exp_tx.push_back(8'h00);
      s = n_tx_start;
      send_frame(2'b00, 32'h4060_0000, 32'h4000_0000);
      n = 0;
      while (n_tx_start < s + 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("pre_reset_tx_count", 32'(n_tx_start - s), 32'h3);
      #1 reset = 1'b0;
      #1 check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // MUL after reset: 2.0 * 1.5 = 3.0
      push_cmd(2'b01, 32'h4000_0000, 32'h3FC0_0000);
      fpu_result = 32'h4040_0000;
      push_tx(32'h4040_0000);
      send_frame(2'b01, 32'h4000_0000, 32'h3FC0_0000);
      wait_idle(200, "mul_idle");
      check("mul_fpu_op", {30'h0, fpu_op}, 32'h1);

      repeat (5) @(negedge clk);
      check("left_cmd", 32'(exp_cmd.size()), 32'h0);
      check("left_tx", 32'(exp_tx.size()), 32'h0);
      check("left_err", 32'(exp_err.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
